// File: rtl/audio_sample_fifo_if.sv
// Handshake bundle between the sample writer/reader and the audio sample FIFO.
//   master : drives wr_en/wr_data/rd_en; observes read data, level and status flags
//   slave  : the FIFO side of the same signals
interface audio_sample_fifo_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 8
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   level;
  logic              empty;
  logic              full;
  logic              low_water;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, level, empty, full, low_water, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, level, empty, full, low_water, overflow, underflow
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// Single-clock FIFO for one channel of signed audio samples.
// Writer is the host data link, reader is the S/PDIF sample request.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : wr_en/wr_data in, rd_en in, rd_data out (registered,
//                       1 cycle after an accepted read), level, empty, full,
//                       low_water, overflow/underflow 1-cycle error pulses
// An underrun leaves rd_data holding the last sample so the output repeats it.
module audio_sample_fifo #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned LOW_MARK = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  audio_sample_fifo_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [DATA_W-1:0] rd_data;
  logic              overflow;
  logic              underflow;

  logic              empty_c;
  logic              full_c;
  logic              wr_acc_c;
  logic              rd_acc_c;

  // Status decoded straight from the registered level.
  assign empty_c = (level == '0);
  assign full_c  = (level == LVL_W'(DEPTH));

  // A read frees a slot in the same edge, so a full FIFO can still take a write
  // alongside a read. An empty FIFO never bypasses write data to the reader.
  assign wr_acc_c = bus.wr_en && (!full_c || bus.rd_en);
  assign rd_acc_c = bus.rd_en && !empty_c;

  // Sample storage; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers, occupancy, read data and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_data   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= bus.wr_en && !wr_acc_c;
      underflow <= bus.rd_en && empty_c;

      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc_c) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        rd_data <= mem[rd_ptr];
      end

      case ({wr_acc_c, rd_acc_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign bus.rd_data   = rd_data;
  assign bus.level     = level;
  assign bus.empty     = empty_c;
  assign bus.full      = full_c;
  assign bus.low_water = (level < LVL_W'(LOW_MARK));
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: a queue-based reference model checked on every
// falling clock edge, plus directed scenarios with literal expectations.
module tb_audio_sample_fifo;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ADDR_W = 8;
  localparam int          DEPTH  = 256;
  localparam int          LOWM   = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic run   = 1'b0;

  int checks   = 0;
  int failures = 0;

  audio_sample_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  audio_sample_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOW_MARK(LOWM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain queue of samples.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_rd = '0;
  logic              m_ov = 1'b0;
  logic              m_un = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_rd = '0;
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      automatic bit wr_ok = bus.wr_en && (q.size() < DEPTH || bus.rd_en);
      automatic bit rd_ok = bus.rd_en && (q.size() > 0);
      m_ov = bus.wr_en && !wr_ok;
      m_un = bus.rd_en && (q.size() == 0);
      if (rd_ok) m_rd = q.pop_front();
      if (wr_ok) q.push_back(bus.wr_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("m_level",     32'(bus.level),     32'(q.size()));
      chk("m_empty",     32'(bus.empty),     32'(q.size() == 0));
      chk("m_full",      32'(bus.full),      32'(q.size() == DEPTH));
      chk("m_low_water", 32'(bus.low_water), 32'(q.size() < LOWM));
      chk("m_rd_data",   32'(bus.rd_data),   32'(m_rd));
      chk("m_overflow",  32'(bus.overflow),  32'(m_ov));
      chk("m_underflow", 32'(bus.underflow), 32'(m_un));
    end
  end

  // One clock: apply inputs, step past the next rising edge.
  task automatic cycle(input logic we, input logic [DATA_W-1:0] wd, input logic re);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    // Reset
    #1 rst_n = 1'b0;
    #1 run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full",  32'(bus.full),  32'd0);
    chk("rst_low",   32'(bus.low_water), 32'd1);
    chk("rst_rd",    32'(bus.rd_data), 32'd0);
    rst_n = 1'b1;
    idle(); idle();
    chk("idle_level", 32'(bus.level), 32'd0);
    chk("idle_empty", 32'(bus.empty), 32'd1);

    // Basic write 1..5 then read back
    for (int i = 1; i <= 5; i++) cycle(1'b1, DATA_W'(i), 1'b0);
    chk("basic_level5", 32'(bus.level), 32'd5);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("basic_rd", 32'(bus.rd_data), 32'(i));
      chk("basic_level", 32'(bus.level), 32'(5 - i));
    end
    idle();
    chk("basic_empty", 32'(bus.empty), 32'd1);

    // Fill to full (pointers start at 5, so this wraps), then overflow
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DATA_W'(i * 32'h10101 + 7), 1'b0);
    chk("fill_full",  32'(bus.full),  32'd1);
    chk("fill_level", 32'(bus.level), 32'd256);
    cycle(1'b1, 24'hDEAD00, 1'b0);
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    chk("ovf_level", 32'(bus.level), 32'd256);
    idle();
    chk("ovf_clear", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("drain_rd", 32'(bus.rd_data), 32'(DATA_W'(i * 32'h10101 + 7)));
    end
    chk("drain_last", 32'(bus.rd_data), 32'(DATA_W'(255 * 32'h10101 + 7)));
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Low-water threshold
    for (int i = 0; i < 63; i++) cycle(1'b1, DATA_W'(32'h200 + i), 1'b0);
    chk("lw_63_level", 32'(bus.level), 32'd63);
    chk("lw_63", 32'(bus.low_water), 32'd1);
    cycle(1'b1, 24'h00023F, 1'b0);
    chk("lw_64_level", 32'(bus.level), 32'd64);
    chk("lw_64", 32'(bus.low_water), 32'd0);
    cycle(1'b0, '0, 1'b1);
    chk("lw_rd", 32'(bus.low_water), 32'd1);
    for (int i = 0; i < 63; i++) cycle(1'b0, '0, 1'b1);

    // Underrun holds last sample
    cycle(1'b1, 24'h7FFFFF, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("ur_last", 32'(bus.rd_data), 32'h7FFFFF);
    cycle(1'b0, '0, 1'b1);
    chk("ur_pulse", 32'(bus.underflow), 32'd1);
    chk("ur_hold",  32'(bus.rd_data), 32'h7FFFFF);
    idle();
    chk("ur_clear", 32'(bus.underflow), 32'd0);

    // Simultaneous read+write at level 10
    for (int k = 0; k < 10; k++) cycle(1'b1, DATA_W'(32'h800500 + k), 1'b0);
    for (int j = 0; j < 20; j++) begin
      cycle(1'b1, DATA_W'(32'h600 + j), 1'b1);
      chk("sim_level", 32'(bus.level), 32'd10);
      chk("sim_rd", 32'(bus.rd_data),
          (j < 10) ? 32'h800500 + 32'(j) : 32'h600 + 32'(j - 10));
    end
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b1);
    chk("sim_drained", 32'(bus.rd_data), 32'h613);

    // Empty with both requests: write only
    cycle(1'b1, 24'h123456, 1'b1);
    chk("ew_level", 32'(bus.level), 32'd1);
    chk("ew_under", 32'(bus.underflow), 32'd1);
    chk("ew_hold",  32'(bus.rd_data), 32'h613);
    cycle(1'b0, '0, 1'b1);
    chk("ew_rd", 32'(bus.rd_data), 32'h123456);

    // Async reset mid-stream
    for (int i = 0; i < 7; i++) cycle(1'b1, DATA_W'(32'hA0 + i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_level", 32'(bus.level), 32'd0);
    chk("ar_empty", 32'(bus.empty), 32'd1);
    chk("ar_rd",    32'(bus.rd_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b1, 24'hABCDEF, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("ar_first", 32'(bus.rd_data), 32'hABCDEF);
    idle();

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
